flash_bus_sequencer: RTL

FLASH_BUS_SEQUENCER -- requirements
Module: flash_bus_sequencer

---
 rtl/flash_bus_sequencer_if.sv | 36 +++
 rtl/flash_bus_sequencer.sv | 86 ++++++++
 2 files changed

// File: rtl/flash_bus_sequencer_if.sv
// flash_bus_sequencer_if: request ports of both requesters plus the parallel flash pins.
interface flash_bus_sequencer_if;
    logic        req0_valid;
    logic [31:0] req0_addr;
    logic        req0_ready;
    logic [31:0] req0_rdata;
    logic        req0_rvalid;
    logic        req1_valid;
    logic        req1_we;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic [31:0] req1_rdata;
    logic        req1_rvalid;
    logic        req1_wdone;
    logic [31:0] flash_addr;
    logic [31:0] flash_dout;
    logic        flash_dout_en;
    logic [31:0] flash_din;
    logic        flash_cs_n;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic        busy;
    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_we, req1_addr, req1_wdata, flash_din,
        output req0_ready, req0_rdata, req0_rvalid, req1_ready, req1_rdata, req1_rvalid,
               req1_wdone, flash_addr, flash_dout, flash_dout_en, flash_cs_n, flash_oe_n,
               flash_we_n, busy
    );
    modport master (
        output req0_valid, req0_addr, req1_valid, req1_we, req1_addr, req1_wdata, flash_din,
        input  req0_ready, req0_rdata, req0_rvalid, req1_ready, req1_rdata, req1_rvalid,
               req1_wdone, flash_addr, flash_dout, flash_dout_en, flash_cs_n, flash_oe_n,
               flash_we_n, busy
    );
endinterface

// File: rtl/flash_bus_sequencer.sv
// flash_bus_sequencer: round-robin arbiter and timed read/write sequencer for an async parallel flash.
module flash_bus_sequencer #(
    parameter int RD_WAIT  = 4,
    parameter int WE_PULSE = 3,
    parameter int TURN     = 1
) (
    input logic s_axi_aclk,
    input logic s_axi_aresetn,
    flash_bus_sequencer_if.slave bus
);
    localparam int MX01 = RD_WAIT > WE_PULSE ? RD_WAIT : WE_PULSE;
    localparam int MX   = MX01 > TURN ? MX01 : TURN;
    localparam int CW   = $clog2(MX + 1);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_TURN} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic last, owner, idle, acc0, acc1, rd_done;
    logic [31:0] addr_q, dout_q, rdata0, rdata1;
    logic rv0, rv1, wd;
    always_comb begin
        idle    = state == S_IDLE && s_axi_aresetn;
        acc0    = idle & bus.req0_valid & (~bus.req1_valid | last);
        acc1    = idle & bus.req1_valid & (~bus.req0_valid | ~last);
        rd_done = state == S_RD && cnt == '0;
        nxt     = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (acc0 || (acc1 && !bus.req1_we)) begin
                    nxt   = S_RD;
                    cnt_n = CW'(RD_WAIT - 1);
                end else if (acc1) nxt = S_WR_SETUP;
            end
            S_RD:       if (cnt == '0) begin nxt = S_TURN; cnt_n = CW'(TURN - 1); end else cnt_n = cnt - CW'(1);
            S_WR_SETUP: begin nxt = S_WR_PULSE; cnt_n = CW'(WE_PULSE - 1); end
            S_WR_PULSE: if (cnt == '0) nxt = S_WR_HOLD; else cnt_n = cnt - CW'(1);
            S_WR_HOLD:  begin nxt = S_TURN; cnt_n = CW'(TURN - 1); end
            S_TURN:     if (cnt == '0) nxt = S_IDLE; else cnt_n = cnt - CW'(1);
            default:    nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            owner  <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
            rv0    <= 1'b0;
            rv1    <= 1'b0;
            wd     <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
            if (acc0 || acc1) begin
                last   <= acc1;
                owner  <= acc1;
                addr_q <= acc1 ? bus.req1_addr : bus.req0_addr;
            end
            if (acc1) dout_q <= bus.req1_wdata;
            // Pulses are registered so they land in the first turnaround cycle.
            rv0 <= rd_done & ~owner;
            rv1 <= rd_done & owner;
            wd  <= state == S_WR_HOLD;
            if (rd_done && !owner) rdata0 <= bus.flash_din;
            if (rd_done && owner) rdata1 <= bus.flash_din;
        end
    end
    assign bus.req0_ready    = acc0;
    assign bus.req1_ready    = acc1;
    assign bus.req0_rdata    = rdata0;
    assign bus.req1_rdata    = rdata1;
    assign bus.req0_rvalid   = rv0;
    assign bus.req1_rvalid   = rv1;
    assign bus.req1_wdone    = wd;
    assign bus.flash_addr    = addr_q;
    assign bus.flash_dout    = dout_q;
    assign bus.flash_cs_n    = state == S_IDLE || state == S_TURN;
    assign bus.flash_oe_n    = state != S_RD;
    assign bus.flash_we_n    = state != S_WR_PULSE;
    assign bus.flash_dout_en = state == S_WR_SETUP || state == S_WR_PULSE || state == S_WR_HOLD;
    assign bus.busy          = state != S_IDLE;
endmodule
